// File: rtl/mem_arb_pkg.sv
// Shared types and the grant decision for the fetch/data memory arbiter.
package mem_arb_pkg;

   localparam int WORD_W = 32;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      I_ACC = 2'd1,
      D_ACC = 2'd2
   } arb_state_t;

   typedef struct packed {
      logic [WORD_W-1:0] addr;
      logic              we;
      logic              is_byte;
      logic              half_word;
      logic              sign_extend;
      logic [WORD_W-1:0] wdata;
   } acc_desc_t;

   // Data wins unless a waiting fetch has hit the starvation limit.
   function automatic arb_state_t arb_decide(input logic i_cand,
                                             input logic d_cand,
                                             input logic starve_full);
      logic force_i;
      force_i = i_cand & starve_full;
      if (d_cand && !force_i) begin
         arb_decide = D_ACC;
      end else if (i_cand) begin
         arb_decide = I_ACC;
      end else begin
         arb_decide = IDLE;
      end
   endfunction

endpackage

// File: rtl/mem_arbiter.sv
// Single-port memory arbiter between the fetch port and the data port,
// with per-port stalls and a fetch starvation guard.
//
// state | meaning
// IDLE  | no access in flight, arbitrating every cycle
// I_ACC | fetch access on the memory, waiting for mem_ack
// D_ACC | data access on the memory, waiting for mem_ack
module mem_arbiter
   import mem_arb_pkg::*;
#(
   parameter int unsigned STARVE_LIMIT = 4
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              i_req,
   input  logic [WORD_W-1:0] i_addr,
   output logic [WORD_W-1:0] i_data,
   output logic              i_valid,
   input  logic              d_req,
   input  logic              d_we,
   input  logic              d_byte,
   input  logic              d_half_word,
   input  logic              d_sign_extend,
   input  logic [WORD_W-1:0] d_addr,
   input  logic [WORD_W-1:0] d_wdata,
   output logic [WORD_W-1:0] d_rdata,
   output logic              d_valid,
   output logic              i_stall,
   output logic              d_stall,
   output logic              mem_req,
   output logic [WORD_W-1:0] mem_addr,
   output logic              mem_we,
   output logic              mem_byte,
   output logic              mem_half_word,
   output logic              mem_sign_extend,
   output logic [WORD_W-1:0] mem_wdata,
   input  logic [WORD_W-1:0] mem_rdata,
   input  logic              mem_ack
);

   localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

   arb_state_t        state_q, state_d;
   acc_desc_t         desc_q, desc_d;
   logic [3:0]        starve_q, starve_d;
   logic [WORD_W-1:0] i_data_q, i_data_d;
   logic [WORD_W-1:0] d_rdata_q, d_rdata_d;
   logic              i_valid_q, i_valid_d;
   logic              d_valid_q, d_valid_d;

   logic i_eff, d_eff, acked, arb_en, i_cand, d_cand, grant_i, grant_d;

   always_comb begin
      i_eff    = i_req & ~i_valid_q;
      d_eff    = d_req & ~d_valid_q;
      acked    = mem_ack & (state_q != IDLE);
      arb_en   = (state_q == IDLE) | acked;
      // The port finishing this cycle steps aside so the other can follow with no bubble.
      i_cand   = i_eff & (state_q != I_ACC);
      d_cand   = d_eff & (state_q != D_ACC);

      state_d  = state_q;
      if (arb_en) begin
         state_d = arb_decide(i_cand, d_cand, starve_q == LIMIT);
      end
      grant_i  = arb_en & (state_d == I_ACC);
      grant_d  = arb_en & (state_d == D_ACC);

      desc_d   = desc_q;
      if (grant_d) begin
         desc_d.addr        = d_addr;
         desc_d.we          = d_we;
         desc_d.is_byte     = d_byte;
         desc_d.half_word   = d_half_word;
         desc_d.sign_extend = d_sign_extend;
         desc_d.wdata       = d_wdata;
      end else if (grant_i) begin
         desc_d             = '0;
         desc_d.addr        = i_addr;
      end

      starve_d = starve_q;
      if (!i_req || grant_i) begin
         starve_d = '0;
      end else if (grant_d && i_eff && (starve_q < LIMIT)) begin
         starve_d = starve_q + 4'd1;
      end

      i_valid_d = acked & (state_q == I_ACC);
      d_valid_d = acked & (state_q == D_ACC);
      i_data_d  = i_valid_d ? mem_rdata : i_data_q;
      d_rdata_d = (d_valid_d && !desc_q.we) ? mem_rdata : d_rdata_q;
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q   <= IDLE;
         desc_q    <= '0;
         starve_q  <= '0;
         i_data_q  <= '0;
         d_rdata_q <= '0;
         i_valid_q <= 1'b0;
         d_valid_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         desc_q    <= desc_d;
         starve_q  <= starve_d;
         i_data_q  <= i_data_d;
         d_rdata_q <= d_rdata_d;
         i_valid_q <= i_valid_d;
         d_valid_q <= d_valid_d;
      end
   end

   assign i_data          = i_data_q;
   assign i_valid         = i_valid_q;
   assign d_rdata         = d_rdata_q;
   assign d_valid         = d_valid_q;
   assign i_stall         = i_req & ~i_valid_q;
   assign d_stall         = d_req & ~d_valid_q;
   assign mem_req         = (state_q != IDLE);
   assign mem_addr        = desc_q.addr;
   assign mem_we          = desc_q.we;
   assign mem_byte        = desc_q.is_byte;
   assign mem_half_word   = desc_q.half_word;
   assign mem_sign_extend = desc_q.sign_extend;
   assign mem_wdata       = desc_q.wdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios with literal expectations plus a
// randomized run, all checked every cycle against a transaction-level model.
module tb_mem_arbiter;

   localparam int LIMIT = 4;

   logic        clock;
   logic        reset;
   logic        i_req;
   logic [31:0] i_addr;
   logic [31:0] i_data;
   logic        i_valid;
   logic        d_req, d_we, d_byte, d_half_word, d_sign_extend;
   logic [31:0] d_addr, d_wdata, d_rdata;
   logic        d_valid, i_stall, d_stall;
   logic        mem_req, mem_we, mem_byte, mem_half_word, mem_sign_extend;
   logic [31:0] mem_addr, mem_wdata, mem_rdata;
   logic        mem_ack;

   mem_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
      .clock(clock), .reset(reset),
      .i_req(i_req), .i_addr(i_addr), .i_data(i_data), .i_valid(i_valid),
      .d_req(d_req), .d_we(d_we), .d_byte(d_byte), .d_half_word(d_half_word),
      .d_sign_extend(d_sign_extend), .d_addr(d_addr), .d_wdata(d_wdata),
      .d_rdata(d_rdata), .d_valid(d_valid), .i_stall(i_stall), .d_stall(d_stall),
      .mem_req(mem_req), .mem_addr(mem_addr), .mem_we(mem_we), .mem_byte(mem_byte),
      .mem_half_word(mem_half_word), .mem_sign_extend(mem_sign_extend),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   int checks = 0;
   int errors = 0;

   // Model: which port owns the memory (0 none, 1 fetch, 2 data), the access it
   // carries, the completion pulses/data, and how long a fetch has been passed over.
   int          m_owner;
   logic [31:0] m_addr, m_wdata, m_idata, m_drdata;
   logic        m_we, m_byte, m_half, m_sx, m_ivalid, m_dvalid;
   int          m_starve;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got=%h expected=%h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic chk1(input string name, input logic act, input logic exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got=%b expected=%b at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_owner = 0; m_addr = '0; m_wdata = '0; m_idata = '0; m_drdata = '0;
      m_we = 0; m_byte = 0; m_half = 0; m_sx = 0; m_ivalid = 0; m_dvalid = 0;
      m_starve = 0;
   endtask

   task automatic model_advance();
      bit i_wait, d_wait, want_i, want_d, forced;
      int finished, winner;
      i_wait   = i_req && !m_ivalid;
      d_wait   = d_req && !m_dvalid;
      finished = mem_ack ? m_owner : 0;
      winner   = 0;
      m_ivalid = (finished == 1);
      m_dvalid = (finished == 2);
      if (finished == 1) m_idata = mem_rdata;
      if (finished == 2 && !m_we) m_drdata = mem_rdata;
      if (m_owner == 0 || finished != 0) begin
         want_i = i_wait && finished != 1;
         want_d = d_wait && finished != 2;
         forced = want_i && (m_starve == LIMIT);
         if (want_d && !forced) winner = 2;
         else if (want_i) winner = 1;
         if (winner == 2) begin
            m_addr = d_addr; m_we = d_we; m_byte = d_byte; m_half = d_half_word;
            m_sx = d_sign_extend; m_wdata = d_wdata;
         end else if (winner == 1) begin
            m_addr = i_addr; m_we = 0; m_byte = 0; m_half = 0; m_sx = 0; m_wdata = '0;
         end
         m_owner = winner;
      end
      if (!i_req || winner == 1) m_starve = 0;
      else if (winner == 2 && i_wait && m_starve < LIMIT) m_starve++;
   endtask

   task automatic model_compare();
      if (!reset) model_reset();
      chk1("mem_req", mem_req, m_owner != 0);
      chk1("i_valid", i_valid, m_ivalid);
      chk1("d_valid", d_valid, m_dvalid);
      chk ("i_data", i_data, m_idata);
      chk ("d_rdata", d_rdata, m_drdata);
      chk1("i_stall", i_stall, i_req & ~m_ivalid);
      chk1("d_stall", d_stall, d_req & ~m_dvalid);
      if (m_owner != 0 || !reset) begin
         chk ("mem_addr", mem_addr, m_addr);
         chk1("mem_we", mem_we, m_we);
         chk1("mem_byte", mem_byte, m_byte);
         chk1("mem_half_word", mem_half_word, m_half);
         chk1("mem_sign_extend", mem_sign_extend, m_sx);
         chk ("mem_wdata", mem_wdata, m_wdata);
      end
      if (reset) model_advance();
   endtask

   task automatic neg();
      @(negedge clock);
      model_compare();
   endtask

   task automatic pos();
      @(posedge clock);
      #1;
   endtask

   bit i_done_prev, d_done_prev;
   int stall_cycles;
   bit seen_valid;

   initial begin
      reset = 0; i_req = 0; i_addr = 0; d_req = 0; d_we = 0; d_byte = 0;
      d_half_word = 0; d_sign_extend = 0; d_addr = 0; d_wdata = 0;
      mem_rdata = 0; mem_ack = 0;
      model_reset();
      neg(); neg();
      chk("reset_i_data", i_data, 32'h0);
      chk1("reset_mem_req", mem_req, 1'b0);
      pos(); reset = 1;

      // Lone fetch, acked in its first memory cycle.
      i_req = 1; i_addr = 32'h100;
      neg();
      chk1("fetch_stall_c0", i_stall, 1'b1);
      pos(); mem_ack = 1; mem_rdata = 32'h8C22_0004;
      neg();
      chk1("fetch_mem_req_c1", mem_req, 1'b1);
      chk ("fetch_mem_addr_c1", mem_addr, 32'h100);
      pos(); mem_ack = 0;
      neg();
      chk1("fetch_valid_c2", i_valid, 1'b1);
      chk ("fetch_data_c2", i_data, 32'h8C22_0004);
      chk1("fetch_stall_c2", i_stall, 1'b0);
      pos(); i_req = 0;
      neg();

      // Collision: data store first, fetch follows on the store's ack cycle.
      pos(); i_req = 1; i_addr = 32'h104;
      d_req = 1; d_addr = 32'h2000; d_we = 1; d_wdata = 32'hDEAD_BEEF;
      neg();
      pos();
      neg();
      chk1("coll_mem_we", mem_we, 1'b1);
      chk ("coll_mem_wdata", mem_wdata, 32'hDEAD_BEEF);
      chk ("coll_mem_addr", mem_addr, 32'h2000);
      pos(); mem_ack = 1; mem_rdata = 32'h1111_1111;
      neg();
      pos(); mem_ack = 0;
      neg();
      chk1("coll_d_valid", d_valid, 1'b1);
      chk1("coll_no_bubble", mem_req, 1'b1);
      chk ("coll_i_addr", mem_addr, 32'h104);
      chk1("coll_i_we", mem_we, 1'b0);
      chk ("coll_d_rdata_kept", d_rdata, 32'h0);
      pos(); d_req = 0; d_we = 0; d_wdata = 0; mem_ack = 1; mem_rdata = 32'h2222_2222;
      neg();
      pos(); mem_ack = 0;
      neg();
      chk1("coll_i_valid", i_valid, 1'b1);
      chk ("coll_i_data", i_data, 32'h2222_2222);
      pos(); i_req = 0;
      neg();

      // Sign-extending byte load.
      pos(); d_req = 1; d_byte = 1; d_sign_extend = 1; d_addr = 32'h2003;
      neg();
      pos(); mem_ack = 1; mem_rdata = 32'hFFFF_FF80;
      neg();
      chk1("byte_mem_byte", mem_byte, 1'b1);
      chk1("byte_mem_sx", mem_sign_extend, 1'b1);
      chk ("byte_mem_addr", mem_addr, 32'h2003);
      pos(); mem_ack = 0;
      neg();
      chk1("byte_d_valid", d_valid, 1'b1);
      chk ("byte_d_rdata", d_rdata, 32'hFFFF_FF80);
      pos(); d_req = 0; d_byte = 0; d_sign_extend = 0;
      neg();
      chk1("byte_no_regrant", mem_req, 1'b0);
      chk1("byte_single_pulse", d_valid, 1'b0);

      // Stall shape with the ack in the fifth memory cycle.
      pos(); d_req = 1; d_addr = 32'h3000;
      stall_cycles = 0; seen_valid = 0;
      for (int c = 0; c < 12; c++) begin
         mem_ack = (c == 5);
         neg();
         if (d_valid) begin
            seen_valid = 1;
            chk1("stall_low_at_valid", d_stall, 1'b0);
            break;
         end
         if (d_stall) stall_cycles++;
         pos();
      end
      chk1("stall_valid_seen", seen_valid, 1'b1);
      chk ("stall_cycles", 32'(stall_cycles), 32'd6);
      pos(); d_req = 0; mem_ack = 0;
      neg();

      // Reset in the middle of a data access.
      pos(); d_req = 1; d_addr = 32'h4000; d_we = 1; d_wdata = 32'h5555_5555;
      neg();
      pos();
      neg();
      chk1("rst_acc_active", mem_req, 1'b1);
      #2 reset = 0;
      #1 chk1("rst_mem_req_drop", mem_req, 1'b0);
      d_req = 0; d_we = 0;
      neg();
      pos(); reset = 1;
      for (int c = 0; c < 5; c++) begin
         mem_ack = c[0];
         neg();
         chk1("rst_no_d_valid", d_valid, 1'b0);
         chk1("rst_idle", mem_req, 1'b0);
         pos();
      end
      mem_ack = 0;

      // Both ports held busy, data advancing its address every completion.
      i_req = 1; i_addr = 32'h500; d_req = 1; d_addr = 32'h6000;
      for (int c = 0; c < 60; c++) begin
         neg();
         pos();
         if (m_dvalid) d_addr = d_addr + 32'd4;
         if (m_ivalid) i_addr = i_addr + 32'd4;
         mem_ack = ($urandom_range(0, 99) < 50);
         mem_rdata = $urandom;
      end
      i_req = 0; d_req = 0; mem_ack = 0;
      neg();

      // Randomized traffic.
      i_done_prev = 0; d_done_prev = 0;
      for (int c = 0; c < 3000; c++) begin
         pos();
         if (!i_req || i_done_prev) begin
            i_req  = ($urandom_range(0, 99) < 40);
            i_addr = $urandom & 32'hFFFF_FFFC;
         end else if ($urandom_range(0, 99) < 3) begin
            i_req = 0;
         end
         if (!d_req || d_done_prev) begin
            d_req         = ($urandom_range(0, 99) < 45);
            d_addr        = $urandom;
            d_we          = $urandom_range(0, 1) == 1;
            d_byte        = $urandom_range(0, 1) == 1;
            d_half_word   = $urandom_range(0, 1) == 1;
            d_sign_extend = $urandom_range(0, 1) == 1;
            d_wdata       = $urandom;
         end else if ($urandom_range(0, 99) < 3) begin
            d_req = 0;
         end
         i_done_prev = m_ivalid;
         d_done_prev = m_dvalid;
         mem_ack   = (m_owner != 0) ? ($urandom_range(0, 99) < 45)
                                    : ($urandom_range(0, 99) < 10);
         mem_rdata = $urandom;
         neg();
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
Shares one single-port memory between the IFU fetch port and the MEM-stage data port of the pipelined processor. Sits between `processor` and a unified memory, and raises per-port stalls while an access is pending. Data accesses take priority over fetches. A starvation guard ensures fetches still make progress under back-to-back loads and stores.

Parameters:
- STARVE_LIMIT, 4: consecutive data grants allowed while i_req is waiting before a fetch is forced; range 1..15.

Ports:
- clock  in  1  system clock; all state on posedge
- reset  in  1  asynchronous, active-low; 0 resets all state
- i_req  in  1  fetch request; held with i_addr until i_valid
- i_addr  in  32 [0:31]  fetch address
- i_data  out  32 [0:31]  fetched instruction, registered
- i_valid  out  1  one-cycle pulse, i_data valid
- d_req  in  1  data request; held with d_* until d_valid
- d_we  in  1  store when 1, load when 0
- d_byte  in  1  byte access
- d_half_word  in  1  halfword access
- d_sign_extend  in  1  sign-extend load
- d_addr  in  32 [0:31]  data address
- d_wdata  in  32 [0:31]  store data
- d_rdata  out  32 [0:31]  load data, registered
- d_valid  out  1  one-cycle pulse, access complete
- i_stall  out  1  i_req & ~i_valid
- d_stall  out  1  d_req & ~d_valid
- mem_req  out  1  access active; held until mem_ack
- mem_addr  out  32 [0:31]  latched address
- mem_we  out  1  latched write enable; 0 for fetch
- mem_byte  out  1  latched byte flag; 0 for fetch
- mem_half_word  out  1  latched halfword flag; 0 for fetch
- mem_sign_extend  out  1  latched sign-extend flag; 0 for fetch
- mem_wdata  out  32 [0:31]  latched store data
- mem_rdata  in  32 [0:31]  memory read data, sampled on mem_ack
- mem_ack  in  1  access complete this cycle; may arrive in the first mem_req cycle

Behaviour:
- Reset (reset==0, async):
  - state=IDLE, starve_cnt=0.
  - All outputs 0, including i_data and d_rdata.
  - An in-flight access is abandoned: mem_req drops immediately, and no valid is produced after reset releases.
- FSM states: IDLE, I_ACC, D_ACC. mem_req=1 exactly in I_ACC and D_ACC.
- Masked requests:
  - i_eff = i_req & ~i_valid; d_eff = d_req & ~d_valid.
  - A requester is therefore never re-granted in its own valid cycle.
- Arbitration runs in IDLE, and in an ACC state on the cycle mem_ack=1:
  - force_i = i_eff & (starve_cnt==STARVE_LIMIT).
  - Grant D if d_eff & ~force_i; else grant I if i_eff; else go to IDLE.
  - On the ack cycle the completing requester is also masked, so the other port can be granted back-to-back with no bubble.
- On grant, the chosen port's request signals are latched into the mem_* registers and held constant through the access. Fetch forces we/byte/half_word/sign_extend to 0 and mem_wdata to 0.
- On mem_ack in I_ACC: i_data<=mem_rdata; i_valid=1 next cycle.
- On mem_ack in D_ACC:
  - Loads: d_rdata<=mem_rdata.
  - Stores: d_rdata holds its previous value.
  - d_valid=1 next cycle in both cases.
- Latency (request to valid):
  - Minimum is request in IDLE at cycle 0, mem_req at cycle 1, ack at cycle 1, valid at cycle 2.
  - In general, valid arrives the cycle after mem_ack.
- starve_cnt:
  - +1 on a D grant while i_eff=1, saturating at STARVE_LIMIT.
  - Cleared on any I grant, or in any cycle with i_req=0.
- Simultaneous i_eff and d_eff in IDLE: D wins unless force_i.
- A request dropped before its grant is not serviced. A request dropped mid-access still completes, and its valid still pulses.
- mem_ack outside I_ACC/D_ACC is ignored.

Decomposition:
- Shared package mem_arb_pkg holds:
  - arb_state_t enum {IDLE, I_ACC, D_ACC};
  - an access-descriptor struct {addr, we, byte, half_word, sign_extend, wdata};
  - constant WORD_W=32.
- No sub-module. The arbitration decision is a function in the package.

Test Plan:
- Lone fetch: i_req=1, i_addr=0x100, mem_ack in the first mem_req cycle, mem_rdata=0x8C220004 -> mem_addr=0x100 at cycle 1, i_valid and i_data=0x8C220004 at cycle 2, i_stall low in cycle 2.
- Collision: i_req and d_req rise together, d_addr=0x2000, d_we=1, d_wdata=0xDEADBEEF, 2-cycle ack:
  - D is served first, with mem_we=1 and mem_wdata=0xDEADBEEF.
  - I_ACC starts on D's ack cycle with no IDLE bubble.
  - d_rdata remains 0.
- Starvation: d_req held high with new addresses each grant, i_req held high, STARVE_LIMIT=4 -> exactly 4 D grants, then an I grant, then starve_cnt=0.
- Byte load: d_byte=1, d_sign_extend=1, d_addr=0x2003, mem_rdata=0xFFFFFF80 -> mem_byte=1, mem_sign_extend=1, d_valid pulses once, d_rdata=0xFFFFFF80, no second D grant in the valid cycle.
- Reset mid-access: reset=0 during D_ACC before ack -> mem_req=0 immediately; after release with no requests, state=IDLE and d_valid never pulses.
- Stall shape: d_req held for a 5-cycle ack latency -> d_stall high for exactly 6 cycles, then low in the d_valid cycle.
